// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipelined_cla_adder                                          |
// | Description : Parametrised two-stage carry-lookahead adder/subtractor with |
// |               two-level lookahead (bit groups, then group carries), status |
// |               flags and a valid/ready handshake with full backpressure.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipelined_cla_adder #(
  parameter int DATA_WIDTH  = 16,
  parameter int GROUP_WIDTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  carry_in,
  input  logic                  sub_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] sum_out,
  output logic                  carry_out,
  output logic                  overflow_out,
  output logic                  zero_out
);

  // Number of first-level groups; the last one is partial when the width
  // is not a multiple of GROUP_WIDTH.
  localparam int C_NUM_GROUPS = (DATA_WIDTH + GROUP_WIDTH - 1) / GROUP_WIDTH;
  localparam int C_MSB        = DATA_WIDTH - 1;

  // ---------------------------------------------------------------------------
  // Handshake / stage enables
  // ---------------------------------------------------------------------------
  logic w_en1;
  logic w_en2;
  logic v1_q;
  logic valid_q;

  // Stage 2 may load when it is empty or its result is being taken; stage 1
  // may load when it is empty or can pass its content on. ready_out is thus
  // combinationally dependent on ready_in.
  assign w_en2     = ~valid_q | ready_in;
  assign w_en1     = ~v1_q | w_en2;
  assign ready_out = w_en1;
  assign valid_out = valid_q;

  // ---------------------------------------------------------------------------
  // Stage 1: operand conditioning and first-level lookahead
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   w_b_eff;
  logic                    cin_d;
  logic [DATA_WIDTH-1:0]   g_d;
  logic [DATA_WIDTH-1:0]   p_d;
  logic [C_NUM_GROUPS-1:0] grp_g_d;
  logic [C_NUM_GROUPS-1:0] grp_p_d;

  // Subtract is A + ~B + 1, so the incoming carry is forced high.
  assign w_b_eff = sub_in ? ~b_in : b_in;
  assign cin_d   = sub_in | carry_in;
  assign g_d     = a_in & w_b_eff;
  assign p_d     = a_in ^ w_b_eff;

  // Stage-1 registers. Bit generates are kept alongside the propagates
  // because the in-group carries of stage 2 need both.
  logic [DATA_WIDTH-1:0]   g_q;
  logic [DATA_WIDTH-1:0]   p_q;
  logic [C_NUM_GROUPS-1:0] grp_g_q;
  logic [C_NUM_GROUPS-1:0] grp_p_q;
  logic                    cin_q;
  logic                    a_msb_q;
  logic                    b_msb_q;

  // ---------------------------------------------------------------------------
  // Stage 2: second-level lookahead and result
  // ---------------------------------------------------------------------------
  logic [C_NUM_GROUPS:0]   w_grp_c;
  logic [DATA_WIDTH-1:0]   w_bit_c;
  logic [DATA_WIDTH-1:0]   sum_d;
  logic                    carry_d;
  logic                    ovf_d;
  logic                    zero_d;

  logic [DATA_WIDTH-1:0]   sum_q;
  logic                    carry_q;
  logic                    ovf_q;
  logic                    zero_q;

  // Per-group lookahead: group G/P in stage 1, bit carries in stage 2.
  for (genvar k = 0; k < C_NUM_GROUPS; k++) begin : g_group
    localparam int C_LO = k * GROUP_WIDTH;
    localparam int C_HI = ((C_LO + GROUP_WIDTH) > DATA_WIDTH) ?
                          (DATA_WIDTH - 1) : (C_LO + GROUP_WIDTH - 1);
    localparam int C_SZ = C_HI - C_LO + 1;

    logic            w_g_grp;
    logic            w_p_grp;
    logic [C_SZ-1:0] w_c_bit;

    // Group generate as a flat sum of products: g[i] & p[i+1..top].
    always_comb begin
      logic term;
      term    = 1'b0;
      w_g_grp = 1'b0;
      w_p_grp = 1'b1;
      for (int i = 0; i < C_SZ; i++) begin
        term = g_d[C_LO + i];
        for (int j = i + 1; j < C_SZ; j++) begin
          term = term & p_d[C_LO + j];
        end
        w_g_grp = w_g_grp | term;
        w_p_grp = w_p_grp & p_d[C_LO + i];
      end
    end

    assign grp_g_d[k] = w_g_grp;
    assign grp_p_d[k] = w_p_grp;

    // Carry into each bit of the group, flattened from the group carry-in.
    always_comb begin
      logic carry;
      logic term;
      carry   = 1'b0;
      term    = 1'b0;
      w_c_bit = '0;
      for (int i = 0; i < C_SZ; i++) begin
        carry = w_grp_c[k];
        for (int m = 0; m < i; m++) begin
          carry = carry & p_q[C_LO + m];
        end
        for (int j = 0; j < i; j++) begin
          term = g_q[C_LO + j];
          for (int m = j + 1; m < i; m++) begin
            term = term & p_q[C_LO + m];
          end
          carry = carry | term;
        end
        w_c_bit[i] = carry;
      end
    end

    assign w_bit_c[C_HI:C_LO] = w_c_bit;
  end

  // Group carry-ins as flat sums of products over registered group G/P and
  // cin; entry C_NUM_GROUPS is the carry out of the MSB.
  always_comb begin
    logic carry;
    logic term;
    carry   = 1'b0;
    term    = 1'b0;
    w_grp_c = '0;
    for (int k = 0; k <= C_NUM_GROUPS; k++) begin
      carry = cin_q;
      for (int m = 0; m < k; m++) begin
        carry = carry & grp_p_q[m];
      end
      for (int j = 0; j < k; j++) begin
        term = grp_g_q[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p_q[m];
        end
        carry = carry | term;
      end
      w_grp_c[k] = carry;
    end
  end

  // Result and flags; overflow compares the effective operand signs.
  assign sum_d   = p_q ^ w_bit_c;
  assign carry_d = w_grp_c[C_NUM_GROUPS];
  assign zero_d  = (sum_d == '0);
  assign ovf_d   = (a_msb_q == b_msb_q) & (sum_d[C_MSB] != a_msb_q);

  // Stage-1 register: capture lookahead terms on an accepted transaction.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v1_q    <= 1'b0;
      g_q     <= '0;
      p_q     <= '0;
      grp_g_q <= '0;
      grp_p_q <= '0;
      cin_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (w_en1) begin
      v1_q <= valid_in;
      if (valid_in) begin
        g_q     <= g_d;
        p_q     <= p_d;
        grp_g_q <= grp_g_d;
        grp_p_q <= grp_p_d;
        cin_q   <= cin_d;
        a_msb_q <= a_in[C_MSB];
        b_msb_q <= w_b_eff[C_MSB];
      end
    end
  end

  // Stage-2 register: results load only with a valid stage-1 entry, so
  // bubbles leave the last result on the data outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (w_en2) begin
      valid_q <= v1_q;
      if (v1_q) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
        zero_q  <= zero_d;
      end
    end
  end

  assign sum_out      = sum_q;
  assign carry_out    = carry_q;
  assign overflow_out = ovf_q;
  assign zero_out     = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipelined_cla_adder                                       |
// | Description : Self-checking bench: W=16 handshake/backpressure scoreboard, |
// |               plus W=1, W=10 and W=64 instances streamed in lockstep.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- main W=16 instance ----------------
  logic        m_valid, m_ready, m_cin, m_sub;
  logic [15:0] m_a, m_b;
  logic        m_rdy_out, m_vout, m_carry, m_ovf, m_zero;
  logic [15:0] m_sum;

  pipelined_cla_adder #(.DATA_WIDTH(16), .GROUP_WIDTH(4)) u_w16 (
    .clk_in(clk), .rst_in(rst), .valid_in(m_valid), .ready_out(m_rdy_out),
    .a_in(m_a), .b_in(m_b), .carry_in(m_cin), .sub_in(m_sub),
    .valid_out(m_vout), .ready_in(m_ready), .sum_out(m_sum),
    .carry_out(m_carry), .overflow_out(m_ovf), .zero_out(m_zero));

  // ---------------- lockstep W=1 / W=10 / W=64 instances ----------------
  logic        s_valid, s_cin, s_sub;
  logic [63:0] s_a, s_b;
  logic [2:0]  x_rdy, x_v, x_c, x_o, x_z;
  logic [0:0]  w1_sum;
  logic [9:0]  w10_sum;
  logic [63:0] w64_sum;

  pipelined_cla_adder #(.DATA_WIDTH(1), .GROUP_WIDTH(4)) u_w1 (
    .clk_in(clk), .rst_in(rst), .valid_in(s_valid), .ready_out(x_rdy[0]),
    .a_in(s_a[0:0]), .b_in(s_b[0:0]), .carry_in(s_cin), .sub_in(s_sub),
    .valid_out(x_v[0]), .ready_in(1'b1), .sum_out(w1_sum),
    .carry_out(x_c[0]), .overflow_out(x_o[0]), .zero_out(x_z[0]));

  pipelined_cla_adder #(.DATA_WIDTH(10), .GROUP_WIDTH(4)) u_w10 (
    .clk_in(clk), .rst_in(rst), .valid_in(s_valid), .ready_out(x_rdy[1]),
    .a_in(s_a[9:0]), .b_in(s_b[9:0]), .carry_in(s_cin), .sub_in(s_sub),
    .valid_out(x_v[1]), .ready_in(1'b1), .sum_out(w10_sum),
    .carry_out(x_c[1]), .overflow_out(x_o[1]), .zero_out(x_z[1]));

  pipelined_cla_adder #(.DATA_WIDTH(64), .GROUP_WIDTH(8)) u_w64 (
    .clk_in(clk), .rst_in(rst), .valid_in(s_valid), .ready_out(x_rdy[2]),
    .a_in(s_a), .b_in(s_b), .carry_in(s_cin), .sub_in(s_sub),
    .valid_out(x_v[2]), .ready_in(1'b1), .sum_out(w64_sum),
    .carry_out(x_c[2]), .overflow_out(x_o[2]), .zero_out(x_z[2]));

  // ---------------- reference model: plain integer arithmetic ----------------
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub,
                                output logic [63:0] s, output logic co,
                                output logic ov, output logic z);
    logic [65:0] mask, ua, ub, full;
    logic signed [65:0] sa, sb, res, hi, lo;
    mask = (66'd1 << w) - 66'd1;
    ua   = {2'b00, a} & mask;
    ub   = {2'b00, b} & mask;
    full = sub ? (ua - ub) : (ua + ub + {65'd0, cin});
    s    = full[63:0] & mask[63:0];
    co   = sub ? (ua >= ub) : full[w];
    sa   = ua[w-1] ? $signed(ua - (66'd1 << w)) : $signed(ua);
    sb   = ub[w-1] ? $signed(ub - (66'd1 << w)) : $signed(ub);
    res  = sub ? (sa - sb) : (sa + sb + $signed({65'd0, cin}));
    hi   = $signed((66'd1 << (w - 1)) - 66'd1);
    lo   = -hi - 66'sd1;
    ov   = (res > hi) || (res < lo);
    z    = (s == 64'd0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- main-instance scoreboard ----------------
  typedef struct {
    logic [15:0] s;
    logic        c, ov, z;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          delivered = 0;
  logic        stall_prev = 1'b0;
  logic [18:0] prev_out = '0;

  // One clock of the main instance: drive, check everything the model
  // predicts for this cycle, update the model, advance past the edge.
  task automatic cyc16(input logic v, input logic r, input logic [15:0] ai,
                       input logic [15:0] bi, input logic ci, input logic si,
                       output logic acc);
    exp_t        e;
    logic [63:0] es;
    logic        ec, eo, ez, exp_v;
    logic [18:0] cur;
    m_valid = v; m_ready = r; m_a = ai; m_b = bi; m_cin = ci; m_sub = si;
    #1;
    // A result is visible two cycles after its acceptance, oldest first.
    exp_v = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
    cur   = {m_sum, m_carry, m_ovf, m_zero};
    chk("ready_out", 64'(m_rdy_out), 64'(!(q.size() == 2 && !r)));
    chk("valid_out", 64'(m_vout), 64'(exp_v));
    if (stall_prev || !exp_v) chk("hold_outputs", 64'(cur), 64'(prev_out));
    if (exp_v && r) begin
      e = q.pop_front();
      chk("sum16", 64'(m_sum), 64'(e.s));
      chk("carry16", 64'(m_carry), 64'(e.c));
      chk("ovf16", 64'(m_ovf), 64'(e.ov));
      chk("zero16", 64'(m_zero), 64'(e.z));
      delivered++;
    end
    acc = v && m_rdy_out;
    if (acc) begin
      model(16, 64'(ai), 64'(bi), ci, si, es, ec, eo, ez);
      e.s = es[15:0]; e.c = ec; e.ov = eo; e.z = ez; e.acc = cyc;
      q.push_back(e);
    end
    stall_prev = exp_v && !r;
    prev_out   = cur;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; m_valid = 1'b0; s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    stall_prev = 1'b0;
    prev_out   = '0;
    chk("rst_valid16", 64'(m_vout), 64'd0);
    chk("rst_outs16", 64'({m_sum, m_carry, m_ovf, m_zero}), 64'd0);
    chk("rst_ready16", 64'(m_rdy_out), 64'd1);
    chk("rst_valid_x", 64'(x_v), 64'd0);
    chk("rst_sum64", w64_sum, 64'd0);
  endtask

  task automatic drain16();
    logic a;
    for (int c = 0; c < 10 && q.size() > 0; c++) cyc16(1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, a);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Bound on the whole run.
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic        acc;
  int          sent, base;
  logic [63:0] va, vb;
  logic        vc, vs;
  logic [63:0] ex_s [3];
  logic        ex_c [3], ex_o [3], ex_z [3];
  logic [63:0] obs_s [3];
  int          widths [3] = '{1, 10, 64};
  localparam int NVEC = 10000;

  initial begin
    rst = 1'b1; m_valid = 0; m_ready = 0; m_a = 0; m_b = 0; m_cin = 0; m_sub = 0;
    s_valid = 0; s_a = 0; s_b = 0; s_cin = 0; s_sub = 0;
    do_reset(2);

    // Directed W=16 corner vectors, back to back.
    cyc16(1, 1, 16'hFFFF, 16'h0001, 0, 0, acc);
    cyc16(1, 1, 16'h7FFF, 16'h0001, 0, 0, acc);
    cyc16(1, 1, 16'h0005, 16'h0007, 0, 1, acc);
    cyc16(1, 1, 16'h8000, 16'h0001, 0, 1, acc);
    cyc16(1, 1, 16'h1234, 16'h1234, 1, 1, acc);
    drain16();

    // Reset with both stages full: nothing from before may emerge.
    cyc16(1, 0, 16'hAAAA, 16'h5555, 1, 0, acc);
    cyc16(1, 0, 16'h0F0F, 16'h00FF, 0, 1, acc);
    cyc16(1, 0, 16'h1111, 16'h2222, 0, 0, acc);
    do_reset(2);
    for (int c = 0; c < 4; c++) cyc16(0, 1, 16'd0, 16'd0, 0, 0, acc);

    // ready_in low on an empty pipe: two accepts, then ready_out drops.
    for (int c = 0; c < 3; c++) cyc16(1, 0, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'($urandom()), acc);
    drain16();

    // Eight transactions under toggling, then held-low, ready_in.
    sent = 0;
    base = delivered;
    for (int c = 0; c < 60 && (sent < 8 || q.size() > 0); c++) begin
      cyc16(sent < 8, (c < 8) ? (c % 2 == 0) : (c >= 13),
            16'($urandom()), 16'($urandom()), 1'($urandom()), 1'($urandom()), acc);
      if (acc) sent++;
    end
    chk("bp_delivered", 64'(delivered - base), 64'd8);

    // Random valid/ready traffic.
    for (int c = 0; c < 400; c++)
      cyc16($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            16'($urandom()), 16'($urandom()), 1'($urandom()), 1'($urandom()), acc);
    drain16();

    // Lockstep stream through the W=1, W=10 and W=64 instances.
    for (int i = 0; i <= NVEC; i++) begin
      if (i == 0) begin
        va = '1; vb = 64'd1; vc = 1'b1; vs = 1'b0;
      end else if (i == 1) begin
        va = '1; vb = 64'd0; vc = 1'b1; vs = 1'b0;
      end else begin
        va = {$urandom(), $urandom()}; vb = {$urandom(), $urandom()};
        vc = 1'($urandom()); vs = 1'($urandom());
      end
      s_valid = (i < NVEC); s_a = va; s_b = vb; s_cin = vc; s_sub = vs;
      @(posedge clk); #1;
      if (i >= 1) begin
        obs_s[0] = 64'(w1_sum); obs_s[1] = 64'(w10_sum); obs_s[2] = w64_sum;
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("valid_w%0d", widths[k]), 64'(x_v[k]), 64'd1);
          chk($sformatf("sum_w%0d", widths[k]), obs_s[k], ex_s[k]);
          chk($sformatf("carry_w%0d", widths[k]), 64'(x_c[k]), 64'(ex_c[k]));
          chk($sformatf("ovf_w%0d", widths[k]), 64'(x_o[k]), 64'(ex_o[k]));
          chk($sformatf("zero_w%0d", widths[k]), 64'(x_z[k]), 64'(ex_z[k]));
        end
      end
      if (i < NVEC)
        for (int k = 0; k < 3; k++)
          model(widths[k], va, vb, vc, vs, ex_s[k], ex_c[k], ex_o[k], ex_z[k]);
    end
    @(posedge clk); #1;
    chk("stream_valid_drop", 64'(x_v), 64'd0);
    chk("stream_ready", 64'(x_rdy), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
